seq_div_rem: RTL and testbench
==============================

// Module: seq_div_rem
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
//  It is the inverse-direction companion of the single-cycle CLA add/sub unit
//  and iterates shift/trial-subtract once per clock. It sits beside the ALU in
//  EX. The pipeline stalls while busy=1 and consumes result on the done pulse.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4)
// PORTS
//  CLK           in   1      clock, rising edge
//  rst_n         in   1      synchronous active-low reset
//  start         in   1      request; accepted only in IDLE
//  rs_1          in   WIDTH  dividend, sampled on accepted start
//  rs_2          in   WIDTH  divisor, sampled on accepted start
//  funct3        in   2      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  busy          out  1      1 in CALC and FIX
//  done          out  1      one-cycle pulse; result valid
//  result        out  WIDTH  quotient (DIV*) or remainder (REM*); held until next accept
//  div_by_zero   out  1      flag for the completed op; held with result
// BEHAVIOUR
//  Reset (rst_n=0 at a CLK edge): state=IDLE.
//   - busy=0, done=0, result=0, div_by_zero=0, count=0.
//   - Aborts any op in flight. No done is issued for the aborted op.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE. Fast path: IDLE -> DONE.
//   IDLE: start=1 latches op, sign flags and |rs_1|, |rs_2|.
//    - Magnitudes are taken only for signed ops (funct3[0]=0).
//    - Next state is CALC with count=0, or DONE on the fast path.
//   CALC: one step per cycle, in this order:
//    - rem <- {rem[W-2:0], quo[W-1]}; quo <- quo<<1.
//    - trial = {1'b0,rem} - {1'b0,div}, computed in WIDTH+1 bits.
//    - If trial >= 0: rem <- trial[W-1:0] and quo[0] <- 1.
//    - Exactly WIDTH steps run; after step WIDTH-1 the next state is FIX.
//   FIX: sign correction, then registers result and div_by_zero; next DONE.
//    - Quotient is negated iff signed op and rs_1[MSB]^rs_2[MSB].
//    - Remainder is negated iff signed op and rs_1[MSB].
//   DONE: done=1 for exactly one cycle; next IDLE. start in DONE is ignored.
//  Latency: start accepted at edge k.
//   - Normal op: done=1 in the cycle after edge k+WIDTH+1.
//   - Fast path: done=1 in the cycle after edge k.
//  Fast path, decided at the accept edge:
//   - rs_2==0: quotient = all ones, remainder = rs_1 (both signed and unsigned).
//     div_by_zero=1.
//   - DIV/REM with rs_1==MSB-only and rs_2==all-ones (signed overflow):
//     quotient = rs_1, remainder = 0, div_by_zero=0.
//  start while busy or done is ignored. Operand inputs are don't-care then.
//  Result width: all arithmetic is in WIDTH bits. abs(MSB-only) stays MSB-only
//   and is correct as an unsigned magnitude.
//  Reset has priority over start at the same edge.
// TESTING (WIDTH=32)
//  1. DIVU 100/7 -> done 34 cycles after start.
//     result=14; REMU 100/7 -> result=2; busy=1 for 33 cycles.
//  2. DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1).
//     REM 7/-2 -> 1.
//  3. DIVU 5/0 -> done 1 cycle after start, result=0xFFFFFFFF, div_by_zero=1.
//     REM 5/0 -> result=5.
//  4. DIV 0x80000000/0xFFFFFFFF -> result=0x80000000, fast path.
//     REM of the same operands -> 0.
//  5. start pulsed every cycle during an op -> ignored.
//     Exactly one done, result unchanged until next accepted start.
//  6. rst_n=0 at CALC step 10 -> next cycle busy=0, done=0, result=0.
//     A new start then completes normally.

Source files
------------

// File: rtl/seq_div_rem.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Runs one shift/trial-subtract per clock on magnitudes, then fixes up the signs.
module seq_div_rem #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] rs_1,
  input  logic [WIDTH-1:0] rs_2,
  input  logic [1:0]       funct3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic             signed_op;
  logic             op_zero;
  logic             op_ovf;
  logic [WIDTH-1:0] abs_1;
  logic [WIDTH-1:0] abs_2;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand decode plus one restoring step on the current partial remainder
  always_comb begin
    signed_op = ~funct3[0];
    op_zero   = (rs_2 == '0);
    op_ovf    = signed_op && (rs_1 == MSB_ONLY) && (rs_2 == '1);
    abs_1     = (signed_op && rs_1[WIDTH-1]) ? -rs_1 : rs_1;
    abs_2     = (signed_op && rs_2[WIDTH-1]) ? -rs_2 : rs_2;
    rem_sh    = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_sh    = {quo[WIDTH-2:0], 1'b0};
    trial     = {1'b0, rem_sh} - {1'b0, dvs};
    q_fix     = neg_q ? -quo : quo;
    r_fix     = neg_r ? -rem : rem;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      is_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_rem <= funct3[1];
            neg_q  <= signed_op & (rs_1[WIDTH-1] ^ rs_2[WIDTH-1]);
            neg_r  <= signed_op & rs_1[WIDTH-1];
            rem    <= '0;
            quo    <= abs_1;
            dvs    <= abs_2;
            count  <= '0;
            // Divide-by-zero and signed overflow have fixed answers; skip the loop
            if (op_zero || op_ovf) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= op_zero;
              if (op_zero) begin
                result <= funct3[1] ? rs_1 : '1;
              end else begin
                result <= funct3[1] ? '0 : rs_1;
              end
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= quo_sh;
          end
          count <= count + CW'(1);
          if (count == CW'(WIDTH-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result      <= is_rem ? r_fix : q_fix;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_rem.sv
// Bench for seq_div_rem: directed ops checked against literals, and an
// arithmetic reference model checked against the outputs every cycle.
module tb_seq_div_rem;

  localparam int unsigned W = 32;

  logic         CLK;
  logic         rst_n;
  logic         start;
  logic [W-1:0] rs_1;
  logic [W-1:0] rs_2;
  logic [1:0]   funct3;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;

  seq_div_rem #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .start       (start),
    .rs_1        (rs_1),
    .rs_2        (rs_2),
    .funct3      (funct3),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state shared by driver and monitor
  bit           mon_en    = 1'b0;
  bit           in_flight = 1'b0;
  int           acc_cyc   = 0;
  int           m_lat     = 0;
  bit           m_fast    = 1'b0;
  logic [W-1:0] m_res     = '0;
  bit           m_dbz     = 1'b0;
  logic [W-1:0] held_res  = '0;
  bit           held_dbz  = 1'b0;
  int           mon_es    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // RV32M semantics straight from integer arithmetic
  task automatic model(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output bit dbz, output bit fast);
    longint sa, sb, q, rm;
    dbz  = (b == 0);
    fast = dbz || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (dbz) begin
      r = f[1] ? a : 32'hFFFF_FFFF;
    end else if (!f[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      rm = sa % sb;
      r  = f[1] ? rm[31:0] : q[31:0];
    end else begin
      r = f[1] ? (a % b) : (a / b);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge CLK) begin
    if (mon_en) begin
      if (in_flight) begin
        mon_es = cyc - acc_cyc;
        chk("busy", 32'(busy), 32'(!m_fast && mon_es <= int'(W)));
        chk("done", 32'(done), 32'(mon_es == m_lat));
        if (mon_es >= m_lat) begin
          chk("result", result, m_res);
          chk("dbz", 32'(div_by_zero), 32'(m_dbz));
          held_res  = m_res;
          held_dbz  = m_dbz;
          in_flight = 1'b0;
        end
      end else begin
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle done", 32'(done), 32'd0);
        chk("idle result", result, held_res);
        chk("idle dbz", 32'(div_by_zero), 32'(held_dbz));
      end
    end
  end

  // Present a start with operands and arm the model (called just after a negedge)
  task automatic launch(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    bit dz, fp;
    start  = 1'b1;
    funct3 = f;
    rs_1   = a;
    rs_2   = b;
    model(f, a, b, r, dz, fp);
    m_res     = r;
    m_dbz     = dz;
    m_fast    = fp;
    m_lat     = fp ? 0 : int'(W) + 1;
    acc_cyc   = cyc + 1;
    in_flight = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input bit edbz,
                        input int elat, input bit spam);
    int n;
    bit got;
    logic [W-1:0] res_s;
    logic dbz_s;
    @(negedge CLK);
    #1;
    launch(f, a, b);
    chk({nm, " model"}, m_res, er);
    n   = 0;
    got = 1'b0;
    res_s = '0;
    dbz_s = 1'b0;
    while (!got && n <= 100) begin
      @(negedge CLK);
      if (done) begin
        got   = 1'b1;
        res_s = result;
        dbz_s = div_by_zero;
      end else begin
        n++;
      end
      #1;
      if (spam) begin
        start  = 1'b1;
        funct3 = 2'($urandom);
        rs_1   = $urandom;
        rs_2   = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles", nm, n);
    end else begin
      chk({nm, " lat"}, 32'(n), 32'(elat));
      chk({nm, " res"}, res_s, er);
      chk({nm, " dbz"}, 32'(dbz_s), 32'(edbz));
    end
    if (spam) begin
      @(negedge CLK);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    rs_1   = '0;
    rs_2   = '0;
    funct3 = 2'b00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst dbz", 32'(div_by_zero), 32'd0);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b0);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33, 1'b0);
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("rem 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 1'b1, 0, 1'b0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0);
    run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("remu max/16", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 33, 1'b0);
    run_op("div min/2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 33, 1'b0);
    run_op("rem min/3", 2'b10, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
    run_op("divu 3/7", 2'b01, 32'd3, 32'd7, 32'd0, 1'b0, 33, 1'b0);
    run_op("div 0/-5", 2'b00, 32'd0, 32'hFFFF_FFFB, 32'd0, 1'b0, 33, 1'b0);
    run_op("spam div 1000/-3", 2'b00, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 1'b0, 33, 1'b1);
    run_op("spam divu 9/0", 2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    repeat (3) @(negedge CLK);

    // Abort an op partway through CALC with reset
    @(negedge CLK);
    #1;
    launch(2'b01, 32'd100, 32'd7);
    @(negedge CLK);
    #1;
    start = 1'b0;
    repeat (9) @(negedge CLK);
    #1;
    rst_n     = 1'b0;
    in_flight = 1'b0;
    held_res  = '0;
    held_dbz  = 1'b0;
    @(negedge CLK);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", result, 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (40) @(negedge CLK);

    run_op("post-rst divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b0);
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
